// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and stage-record type for the EX-stage hazard/forwarding unit.
// Holds the forward-select codes, the zero-register id and the forwarding priority helper.
package hazard_forward_unit_pkg;

  localparam int REG_DEST_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_DEST_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_DEST_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '{dest: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

  // Youngest producer wins: an EX match beats a MEM match; $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic                  uses,
                                         input logic [REG_DEST_W-1:0] src,
                                         input stage_rec_t            ex,
                                         input stage_rec_t            mem);
    if (uses && ex.reg_write && (ex.dest != REG_ZERO) && (ex.dest == src)) begin
      return FWD_MEM;
    end
    if (uses && mem.reg_write && (mem.dest != REG_ZERO) && (mem.dest == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-side request and EX-side control bundle between pipeline control and the hazard unit.
// master = pipeline control (drives ID fields, hold, flush); slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  import hazard_forward_unit_pkg::*;

  logic             hold;
  logic             flush;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;

  logic             stall;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_count;
  stage_rec_t       wb_rec;

  modport master (
    output hold, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read,
    input  stall, forward_a, forward_b, ex_bubble, stall_count, wb_rec
  );

  modport slave (
    input  hold, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read,
    output stall, forward_a, forward_b, ex_bubble, stall_count, wb_rec
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage record (dest/reg_write/mem_read); one-cycle register.
// hold freezes it, bubble_i loads an empty record, reset is synchronous active-low.
module hazard_stage_reg
  import hazard_forward_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold_i,
  input  logic       bubble_i,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  stage_rec_t rec_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_q <= STAGE_BUBBLE;
    end else if (!hold_i) begin
      rec_q <= bubble_i ? STAGE_BUBBLE : rec_i;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forward selects and load-use stall for the EX-stage ALU muxes; selects register one edge after ID.
// hold freezes every register; stall is combinational and suppressed by flush.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = REG_DEST_W,
  parameter int CNT_W = 16
)(
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  stage_rec_t       id_rec;
  stage_rec_t       ex_rec;
  stage_rec_t       mem_rec;
  stage_rec_t       wb_rec;

  logic             ex_load_hit;
  logic             stall;
  logic             ex_squash;

  logic [1:0]       fwd_a_d, fwd_a_q;
  logic [1:0]       fwd_b_d, fwd_b_q;
  logic             ex_bubble_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign id_rs  = bus.id_rs;
  assign id_rt  = bus.id_rt;
  assign id_rec = '{dest: bus.id_dest, reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};

  // A load in EX cannot feed ID's operands in time; one bubble lets it reach MEM first.
  assign ex_load_hit = ex_rec.mem_read && (ex_rec.dest != REG_ZERO) &&
                       ((bus.id_uses_rs && (id_rs == ex_rec.dest)) ||
                        (bus.id_uses_rt && (id_rt == ex_rec.dest)));
  assign stall     = !bus.flush && ex_load_hit;
  assign ex_squash = stall || bus.flush;

  assign fwd_a_d = fwd_sel(bus.id_uses_rs, id_rs, ex_rec, mem_rec);
  assign fwd_b_d = fwd_sel(bus.id_uses_rt, id_rt, ex_rec, mem_rec);
  assign cnt_d   = (stall && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  hazard_stage_reg u_ex_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (bus.hold),
    .bubble_i (ex_squash),
    .rec_i    (id_rec),
    .rec_o    (ex_rec)
  );

  hazard_stage_reg u_mem_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (bus.hold),
    .bubble_i (1'b0),
    .rec_i    (ex_rec),
    .rec_o    (mem_rec)
  );

  hazard_stage_reg u_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (bus.hold),
    .bubble_i (1'b0),
    .rec_i    (mem_rec),
    .rec_o    (wb_rec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      ex_bubble_q <= 1'b1;
      cnt_q       <= '0;
    end else if (!bus.hold) begin
      if (ex_squash) begin
        fwd_a_q     <= FWD_RF;
        fwd_b_q     <= FWD_RF;
        ex_bubble_q <= 1'b1;
      end else begin
        fwd_a_q     <= fwd_a_d;
        fwd_b_q     <= fwd_b_d;
        ex_bubble_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.forward_a   = fwd_a_q;
  assign bus.forward_b   = fwd_b_q;
  assign bus.ex_bubble   = ex_bubble_q;
  assign bus.stall_count = cnt_q;
  assign bus.wb_rec      = wb_rec;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Control-side producer for the EX-stage 3:1 forwarding muxes in the 5-stage MIPS pipeline.
- Tracks destination and control info for instructions in EX, MEM and WB.
- Registers 2-bit forward selects so they are valid while the consumer instruction sits in EX.
- Generates the load-use stall and bubble, and keeps a saturating stall counter for performance checks.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; clears all state on a clk edge while low
- hold  input  1  global pipeline freeze (memory wait); all state held
- flush  input  1  squash the ID instruction (taken branch/jump); it enters EX as a bubble
- id_rs  input  REG_W  rs field of the instruction in ID
- id_rt  input  REG_W  rt field of the instruction in ID
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- id_dest  input  REG_W  post-regDst destination of the ID instruction
- id_reg_write  input  1  ID instruction writes the register file
- id_mem_read  input  1  ID instruction is a load
- stall  output  1  combinational; hold PC and IF/ID, insert bubble into EX
- forward_a  output  2  registered select for the ALU A mux
- forward_b  output  2  registered select for the ALU B mux
- ex_bubble  output  1  registered; EX currently holds a bubble
- stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding, fixed:
  - 00: register-file value
  - 01: MEM/WB result
  - 10: EX/MEM ALU result
  - 11: never driven
- Internal stage records (dest, reg_write, mem_read) for EX, MEM and WB; all valid bits act as reg_write/mem_read.
- Reset (reset==0 at a clk edge) clears:
  - all records
  - forward_a/b to 00
  - ex_bubble to 1
  - stall_count to 0
  - stall then evaluates to 0.
- Register-file writes are write-through within the cycle, so WB needs no forwarding.
- stall (combinational) = !flush && ex.mem_read && ex.dest!=0 && ((id_uses_rs && id_rs==ex.dest) || (id_uses_rt && id_rt==ex.dest)).
- On each clk edge with reset==1 and hold==0:
  - wb <= mem, mem <= ex.
  - If stall or flush: ex <= bubble (reg_write=0, mem_read=0, dest=0), ex_bubble<=1, forward_a/b<=00.
  - Otherwise: ex <= ID record, ex_bubble<=0.
  - Otherwise, forward_a: 10 if id_uses_rs, ex.reg_write, ex.dest!=0 and ex.dest==id_rs; else 01 if the same test passes against the mem record; else 00.
  - forward_b: same rule using id_uses_rt and id_rt.
  - EX match has priority over MEM (youngest producer wins).
  - stall_count increments when stall==1 and saturates at all-ones.
- hold==1: every register keeps its value. stall stays combinational, and the consumer ignores it while hold is set. flush is not latched; upstream keeps flush asserted until hold drops.
- flush and stall together: flush wins, stall=0, no count.
- Register 0 is never a forwarding or stall source.
- A load in MEM matching ID forwards with 01, since the result is available from WB next cycle; no stall.
- Latency: selects are visible one edge after the instruction leaves ID, coincident with it in EX.

Decomposition:
- Shared package/header holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO=5'd0
  - stage-record struct/field widths
- One natural sub-module, hazard_stage_reg: a dest/reg_write/mem_read record with hold, bubble-load and active-low synchronous reset, instantiated three times.
- Compare/priority logic stays in the top.

Test Plan:
- Reset low two edges with random inputs -> forward_a=forward_b=00, ex_bubble=1, stall=0, stall_count=0; release reset, all remain until a writing instruction arrives.
- add $3 (dest 3, rw) then next cycle sub reading rs=3 -> sub in EX with forward_a=10; one cycle later an instruction reading rt=3 gets forward_b=01.
- lw $5 then add reading rs=5 immediately -> stall=1 for exactly one cycle, ex_bubble=1 next edge; the re-presented add then gets forward_a=01; stall_count=1.
- Writer with dest 0 followed by reader of $0 -> forward 00 and no stall; writer $7 in both EX and MEM (two back-to-back writes) -> reader gets 10, not 01.
- Load-use condition with flush=1 simultaneously -> stall=0, bubble enters EX, count unchanged; hold=1 for 3 cycles mid-sequence -> outputs and stall_count frozen, sequence resumes identically.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_count saturates at 15; reset low mid-stall -> all outputs return to reset values next edge.
